// File: rtl/neureka_double_infeat_buffer_ctrl_if.sv
// Handshake bundle between the neureka controller, the load streamer, the engine
// and the ping-pong input-feature buffer sequencer.
interface neureka_double_infeat_buffer_ctrl_if #(
  parameter int TILE_CNT_W = 16
);
  logic                  clear_i;
  logic                  enable_i;
  logic                  start_i;
  logic [TILE_CNT_W-1:0] cfg_nb_tiles_i;
  logic                  fill_done_i;
  logic                  drain_done_i;
  logic                  fill_en_o;
  logic                  drain_en_o;
  logic                  write_sel_o;
  logic                  read_sel_o;
  logic [1:0]            bank_full_o;
  logic [TILE_CNT_W-1:0] loaded_cnt_o;
  logic [TILE_CNT_W-1:0] drained_cnt_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;

  modport master (
    output clear_i, enable_i, start_i, cfg_nb_tiles_i, fill_done_i, drain_done_i,
    input  fill_en_o, drain_en_o, write_sel_o, read_sel_o, bank_full_o,
           loaded_cnt_o, drained_cnt_o, busy_o, done_o, err_o
  );

  modport slave (
    input  clear_i, enable_i, start_i, cfg_nb_tiles_i, fill_done_i, drain_done_i,
    output fill_en_o, drain_en_o, write_sel_o, read_sel_o, bank_full_o,
           loaded_cnt_o, drained_cnt_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/neureka_double_infeat_buffer_ctrl.sv
// Ping-pong sequencer for the even/odd input-feature buffer banks: steers the
// streamer's write bank and the engine's read bank, tracking per-bank fullness.
module neureka_double_infeat_buffer_ctrl #(
  parameter int TILE_CNT_W = 16
) (
  input logic                                 clk_i,
  input logic                                 rst_i,
  neureka_double_infeat_buffer_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [TILE_CNT_W-1:0] CNT_ONE = TILE_CNT_W'(1);

  state_t                state_q, state_d;
  logic [TILE_CNT_W-1:0] nb_tiles_q, nb_tiles_d;
  logic [TILE_CNT_W-1:0] loaded_q, loaded_d;
  logic [TILE_CNT_W-1:0] drained_q, drained_d;
  logic [1:0]            full_q, full_d;
  logic                  wsel_q, wsel_d;
  logic                  rsel_q, rsel_d;
  logic                  err_q, err_d;
  logic                  fill_en_q, fill_en_d;
  logic                  drain_en_q, drain_en_d;
  logic                  busy_q, done_q;
  logic                  fill_ok, drain_ok;

  always_comb begin
    state_d    = state_q;
    nb_tiles_d = nb_tiles_q;
    loaded_d   = loaded_q;
    drained_d  = drained_q;
    full_d     = full_q;
    wsel_d     = wsel_q;
    rsel_d     = rsel_q;
    err_d      = err_q;
    fill_ok    = 1'b0;
    drain_ok   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          nb_tiles_d = bus.cfg_nb_tiles_i;
          loaded_d   = '0;
          drained_d  = '0;
          full_d     = 2'b00;
          wsel_d     = 1'b0;
          rsel_d     = 1'b0;
          err_d      = 1'b0;
          state_d    = (bus.cfg_nb_tiles_i == '0) ? DONE : RUN;
        end
        if (bus.fill_done_i || bus.drain_done_i) err_d = 1'b1;
      end
      RUN: begin
        fill_ok  = bus.fill_done_i && fill_en_q;
        drain_ok = bus.drain_done_i && drain_en_q;
        if ((bus.fill_done_i && !fill_en_q) || (bus.drain_done_i && !drain_en_q)) err_d = 1'b1;
        // Each side indexes with its own pre-cycle select, so a same-cycle fill
        // and drain never touch the same flag when both are legal.
        if (fill_ok) begin
          full_d[wsel_q] = 1'b1;
          wsel_d         = !wsel_q;
          loaded_d       = loaded_q + CNT_ONE;
        end
        if (drain_ok) begin
          full_d[rsel_q] = 1'b0;
          rsel_d         = !rsel_q;
          drained_d      = drained_q + CNT_ONE;
        end
        if (drained_d == nb_tiles_q) state_d = DONE;
      end
      DONE: begin
        if (bus.fill_done_i || bus.drain_done_i) err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Enables are registered from next-state values so a fill is drainable next cycle.
    fill_en_d  = (state_d == RUN) && !full_d[wsel_d] && (loaded_d < nb_tiles_d);
    drain_en_d = (state_d == RUN) && full_d[rsel_d];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clear_i) begin
      state_q    <= IDLE;
      loaded_q   <= '0;
      drained_q  <= '0;
      full_q     <= 2'b00;
      wsel_q     <= 1'b0;
      rsel_q     <= 1'b0;
      err_q      <= 1'b0;
      fill_en_q  <= 1'b0;
      drain_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (bus.enable_i) begin
      state_q    <= state_d;
      loaded_q   <= loaded_d;
      drained_q  <= drained_d;
      full_q     <= full_d;
      wsel_q     <= wsel_d;
      rsel_q     <= rsel_d;
      err_q      <= err_d;
      fill_en_q  <= fill_en_d;
      drain_en_q <= drain_en_d;
      busy_q     <= (state_d == RUN);
      done_q     <= (state_d == DONE);
    end
  end

  // Tile count is only consulted in RUN, after a start has loaded it.
  always_ff @(posedge clk_i) begin
    if (bus.enable_i) nb_tiles_q <= nb_tiles_d;
  end

  assign bus.fill_en_o     = fill_en_q;
  assign bus.drain_en_o    = drain_en_q;
  assign bus.write_sel_o   = wsel_q;
  assign bus.read_sel_o    = rsel_q;
  assign bus.bank_full_o   = full_q;
  assign bus.loaded_cnt_o  = loaded_q;
  assign bus.drained_cnt_o = drained_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_neureka_double_infeat_buffer_ctrl.sv
// Directed and random checks of the ping-pong buffer sequencer against a
// tile-count model: tile k lives in bank k%2 while loaded > k >= drained.
module tb_neureka_double_infeat_buffer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  int m_phase = 0;
  int m_nb = 0;
  int m_L = 0;
  int m_D = 0;
  int m_err = 0;

  always #5 clk = ~clk;

  neureka_double_infeat_buffer_ctrl_if #(.TILE_CNT_W(16)) ifc ();

  neureka_double_infeat_buffer_ctrl #(.TILE_CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  function automatic int m_fill_en();
    return (m_phase == 1 && (m_L - m_D) < 2 && m_L < m_nb) ? 1 : 0;
  endfunction

  function automatic int m_full(input int b);
    for (int k = m_D; k < m_L; k++) if (k % 2 == b) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int fe, de;
    if (rst || ifc.clear_i) begin
      m_phase = 0; m_L = 0; m_D = 0; m_err = 0;
    end else if (ifc.enable_i) begin
      case (m_phase)
        0: begin
          if (ifc.start_i) begin
            m_nb = int'(ifc.cfg_nb_tiles_i);
            m_L = 0; m_D = 0; m_err = 0;
            m_phase = (m_nb == 0) ? 2 : 1;
          end
          if (ifc.fill_done_i || ifc.drain_done_i) m_err = 1;
        end
        1: begin
          fe = m_fill_en();
          de = (m_L > m_D) ? 1 : 0;
          if ((ifc.fill_done_i && fe == 0) || (ifc.drain_done_i && de == 0)) m_err = 1;
          if (ifc.fill_done_i && fe == 1) m_L++;
          if (ifc.drain_done_i && de == 1) m_D++;
          if (m_D == m_nb) m_phase = 2;
        end
        default: begin
          if (ifc.fill_done_i || ifc.drain_done_i) m_err = 1;
          m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic check_all();
    chk("busy",     32'(ifc.busy_o),        32'(m_phase == 1));
    chk("done",     32'(ifc.done_o),        32'(m_phase == 2));
    chk("err",      32'(ifc.err_o),         m_err);
    chk("fill_en",  32'(ifc.fill_en_o),     m_fill_en());
    chk("drain_en", 32'(ifc.drain_en_o),    32'(m_phase == 1 && m_L > m_D));
    chk("wsel",     32'(ifc.write_sel_o),   m_L % 2);
    chk("rsel",     32'(ifc.read_sel_o),    m_D % 2);
    chk("full",     32'(ifc.bank_full_o),   m_full(1) * 2 + m_full(0));
    chk("loaded",   32'(ifc.loaded_cnt_o),  m_L);
    chk("drained",  32'(ifc.drained_cnt_o), m_D);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
    ifc.start_i = 1'b0; ifc.fill_done_i = 1'b0; ifc.drain_done_i = 1'b0;
    ifc.clear_i = 1'b0; rst = 1'b0;
  endtask

  task automatic go(input int nb);
    ifc.start_i = 1'b1;
    ifc.cfg_nb_tiles_i = 16'(nb);
    step();
  endtask

  initial begin
    int eng, nf, bubble, sawfull, full_fill, got_done, first_drain;
    int wseq[8];

    ifc.clear_i = 1'b0; ifc.enable_i = 1'b1; ifc.start_i = 1'b0;
    ifc.cfg_nb_tiles_i = '0; ifc.fill_done_i = 1'b0; ifc.drain_done_i = 1'b0;

    // Reset
    @(negedge clk);
    rst = 1'b1; step();
    rst = 1'b1; step();
    chk("rst_busy", 32'(ifc.busy_o), 0);
    chk("rst_full", 32'(ifc.bank_full_o), 0);

    // Zero-tile job
    go(0);
    chk("z_done", 32'(ifc.done_o), 1);
    chk("z_busy", 32'(ifc.busy_o), 0);
    chk("z_err",  32'(ifc.err_o), 0);
    step();
    chk("z_done_end", 32'(ifc.done_o), 0);

    // Single tile
    go(1);
    chk("t1_fill_en", 32'(ifc.fill_en_o), 1);
    chk("t1_wsel", 32'(ifc.write_sel_o), 0);
    ifc.fill_done_i = 1'b1; step();
    chk("t1_full", 32'(ifc.bank_full_o), 1);
    chk("t1_drain_en", 32'(ifc.drain_en_o), 1);
    chk("t1_fill_en0", 32'(ifc.fill_en_o), 0);
    ifc.drain_done_i = 1'b1; step();
    chk("t1_done", 32'(ifc.done_o), 1);
    chk("t1_drained", 32'(ifc.drained_cnt_o), 1);
    step();

    // Four tiles, instant streamer, three-cycle engine
    go(4);
    eng = 0; nf = 0; bubble = 0; sawfull = 0; full_fill = 0; got_done = 0; first_drain = 0;
    for (int c = 0; c < 100 && got_done == 0; c++) begin
      if (ifc.fill_en_o) begin
        ifc.fill_done_i = 1'b1;
        if (nf < 8) wseq[nf] = int'(ifc.write_sel_o);
        nf++;
      end
      if (ifc.bank_full_o == 2'b11) begin
        sawfull = 1;
        if (ifc.fill_en_o) full_fill++;
      end
      if (ifc.drain_en_o) begin
        first_drain = 1;
        if (eng == 2) begin ifc.drain_done_i = 1'b1; eng = 0; end
        else eng++;
      end else if (first_drain == 1 && ifc.busy_o) bubble++;
      step();
      if (ifc.done_o) got_done = 1;
    end
    chk("t4_done_seen", got_done, 1);
    chk("t4_drained", 32'(ifc.drained_cnt_o), 4);
    chk("t4_nfills", nf, 4);
    for (int i = 0; i < 4; i++) chk("t4_wsel_seq", wseq[i], i % 2);
    chk("t4_saw_full", sawfull, 1);
    chk("t4_fill_when_full", full_fill, 0);
    chk("t4_bubbles", bubble, 0);
    step();

    // Same-cycle fill and drain
    go(3);
    ifc.fill_done_i = 1'b1; step();
    chk("sim_pre_full", 32'(ifc.bank_full_o), 1);
    ifc.fill_done_i = 1'b1; ifc.drain_done_i = 1'b1; step();
    chk("sim_full", 32'(ifc.bank_full_o), 2);
    chk("sim_wsel", 32'(ifc.write_sel_o), 0);
    chk("sim_rsel", 32'(ifc.read_sel_o), 1);
    chk("sim_loaded", 32'(ifc.loaded_cnt_o), 2);
    chk("sim_drained", 32'(ifc.drained_cnt_o), 1);
    rst = 1'b1; step();

    // Protocol errors
    go(2);
    ifc.drain_done_i = 1'b1; step();
    chk("err_drain", 32'(ifc.err_o), 1);
    chk("err_drained", 32'(ifc.drained_cnt_o), 0);
    ifc.start_i = 1'b1; ifc.cfg_nb_tiles_i = 16'd7; step();
    chk("err_start_busy", 32'(ifc.busy_o), 1);
    chk("err_start_noerr", 32'(ifc.err_o), 1);
    ifc.fill_done_i = 1'b1; step();
    ifc.fill_done_i = 1'b1; step();
    ifc.drain_done_i = 1'b1; step();
    ifc.drain_done_i = 1'b1; step();
    chk("err_job_done", 32'(ifc.done_o), 1);
    step();
    go(1);
    chk("err_cleared", 32'(ifc.err_o), 0);

    // Clear mid-job
    rst = 1'b1; step();
    go(4);
    ifc.fill_done_i = 1'b1; step();
    ifc.fill_done_i = 1'b1; step();
    chk("clr_loaded_pre", 32'(ifc.loaded_cnt_o), 2);
    ifc.clear_i = 1'b1; step();
    chk("clr_busy", 32'(ifc.busy_o), 0);
    chk("clr_loaded", 32'(ifc.loaded_cnt_o), 0);
    chk("clr_full", 32'(ifc.bank_full_o), 0);
    chk("clr_wsel", 32'(ifc.write_sel_o), 0);
    go(2);
    ifc.fill_done_i = 1'b1; step();
    ifc.drain_done_i = 1'b1; step();
    ifc.fill_done_i = 1'b1; step();
    ifc.drain_done_i = 1'b1; step();
    chk("clr_job2_done", 32'(ifc.done_o), 1);
    step();

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      ifc.enable_i       = ($urandom_range(0, 7) != 0);
      ifc.start_i        = ($urandom_range(0, 7) == 0);
      ifc.cfg_nb_tiles_i = 16'($urandom_range(0, 5));
      ifc.fill_done_i    = ($urandom_range(0, 2) == 0);
      ifc.drain_done_i   = ($urandom_range(0, 2) == 0);
      ifc.clear_i        = ($urandom_range(0, 99) == 0);
      rst                = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
